// File: rtl/pong_pkg.sv
// Shared pong definitions: screen row limits and the paddle state encoding.
// Ball, pixel and paddle logic all import this so that the playfield
// geometry and the state encoding stay the same everywhere.
package pong_pkg;

    // Playfield row limits, shared with the ball and pixel logic
    localparam int PONG_SCREEN_TOP = 0;
    localparam int PONG_SCREEN_BOT = 479;

    // Paddle motion state; the unused code 2'b11 falls back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DN   = 2'b10
    } paddle_state_t;

endpackage

// File: rtl/paddle_vel_ramp.sv
// Paddle velocity ramp: holds the current speed and the frame counter that
// paces acceleration.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : direction changed; restart from V_MIN
//   step       : a moving frame happened; advance the ramp
//   clamp      : the move hit a wall; restart from V_MIN (wins over step)
//   vel        : current speed in rows per frame
module paddle_vel_ramp
    import pong_pkg::*;
#(
    parameter int Y_W        = 10,
    parameter int V_MIN      = 2,
    parameter int V_MAX      = 8,
    parameter int ACC_FRAMES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           step,
    input  logic           clamp,
    output logic [Y_W-1:0] vel
);

    localparam int ACC_W = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;

    logic [Y_W-1:0]   vel_r;
    logic [ACC_W-1:0] acc_cnt_r;

    // Speed and acceleration counter; restart wins over advancing
    always_ff @(posedge clk) begin
        if (reset || clear || clamp) begin
            vel_r     <= Y_W'(V_MIN);
            acc_cnt_r <= {ACC_W{1'b0}};
        end else if (step) begin
            if (acc_cnt_r == ACC_W'(ACC_FRAMES - 1)) begin
                acc_cnt_r <= {ACC_W{1'b0}};
                if (vel_r >= Y_W'(V_MAX)) begin
                    vel_r <= vel_r;
                end else begin
                    vel_r <= vel_r + Y_W'(1);
                end
            end else begin
                acc_cnt_r <= acc_cnt_r + ACC_W'(1);
            end
        end else begin
            vel_r     <= vel_r;
            acc_cnt_r <= acc_cnt_r;
        end
    end

    assign vel = vel_r;

endmodule

// File: rtl/paddle_ctrl.sv
// Pong paddle controller: moves one paddle vertically once per frame with an
// accelerating speed ramp, clamped to the playfield.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   btn_up, btn_dn : debounced button levels
//   frame_tick     : one-cycle pulse per video frame
//   paddle_top/bot : current top row and bottom row (top + PAD_H - 1)
//   moving         : a direction is currently latched
//   at_limit       : paddle pinned against the wall it is being pushed into
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int Y_W        = 10,
    parameter int SCREEN_TOP = PONG_SCREEN_TOP,
    parameter int SCREEN_BOT = PONG_SCREEN_BOT,
    parameter int PAD_H      = 72,
    parameter int Y_INIT     = 204,
    parameter int V_MIN      = 2,
    parameter int V_MAX      = 8,
    parameter int ACC_FRAMES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           btn_up,
    input  logic           btn_dn,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_top,
    output logic [Y_W-1:0] paddle_bot,
    output logic           moving,
    output logic           at_limit
);

    localparam int YW1 = Y_W + 1;
    // Extended-width limits so wall arithmetic never wraps
    localparam logic [Y_W:0] TOP_LIM = YW1'(SCREEN_TOP);
    localparam logic [Y_W:0] BOT_LIM = YW1'(SCREEN_BOT - PAD_H + 1);

    paddle_state_t  state_r;
    paddle_state_t  state_nxt_s;
    logic [Y_W-1:0] paddle_top_r;
    logic [Y_W-1:0] top_nxt_s;
    logic [Y_W-1:0] vel_s;
    logic [Y_W:0]   top_ext_s;
    logic [Y_W:0]   vel_ext_s;
    logic [Y_W:0]   up_raw_s;
    logic [Y_W:0]   dn_raw_s;
    logic           up_only_s;
    logic           dn_only_s;
    logic           move_up_s;
    logic           move_dn_s;
    logic           move_s;
    logic           clamp_s;
    logic           state_chg_s;

    assign up_only_s = btn_up & ~btn_dn;
    assign dn_only_s = btn_dn & ~btn_up;

    // Direction state decode, evaluated every clock
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (up_only_s)      state_nxt_s = UP;
                else if (dn_only_s) state_nxt_s = DN;
                else                state_nxt_s = IDLE;
            end
            UP: begin
                if (dn_only_s)      state_nxt_s = DN;
                else if (up_only_s) state_nxt_s = UP;
                else                state_nxt_s = IDLE;
            end
            DN: begin
                if (up_only_s)      state_nxt_s = UP;
                else if (dn_only_s) state_nxt_s = DN;
                else                state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign state_chg_s = (state_nxt_s != state_r);

    // Motion needs the latched direction to still be held at the tick, so a
    // press or release on the tick cycle itself moves nothing
    assign move_up_s = frame_tick & (state_r == UP) & up_only_s;
    assign move_dn_s = frame_tick & (state_r == DN) & dn_only_s;
    assign move_s    = move_up_s | move_dn_s;

    // Candidate position and clamp detection using the current speed
    always_comb begin
        top_ext_s = {1'b0, paddle_top_r};
        vel_ext_s = {1'b0, vel_s};
        up_raw_s  = top_ext_s - vel_ext_s;
        dn_raw_s  = top_ext_s + vel_ext_s;
        top_nxt_s = paddle_top_r;
        clamp_s   = 1'b0;
        if (move_up_s) begin
            // Compared as top < vel + limit so a too-large step cannot wrap
            if (top_ext_s < (vel_ext_s + TOP_LIM)) begin
                top_nxt_s = TOP_LIM[Y_W-1:0];
                clamp_s   = 1'b1;
            end else begin
                top_nxt_s = up_raw_s[Y_W-1:0];
                clamp_s   = 1'b0;
            end
        end else if (move_dn_s) begin
            if (dn_raw_s > BOT_LIM) begin
                top_nxt_s = BOT_LIM[Y_W-1:0];
                clamp_s   = 1'b1;
            end else begin
                top_nxt_s = dn_raw_s[Y_W-1:0];
                clamp_s   = 1'b0;
            end
        end else begin
            top_nxt_s = paddle_top_r;
            clamp_s   = 1'b0;
        end
    end

    // State and position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            paddle_top_r <= Y_W'(Y_INIT);
        end else begin
            state_r      <= state_nxt_s;
            paddle_top_r <= top_nxt_s;
        end
    end

    paddle_vel_ramp #(
        .Y_W        (Y_W),
        .V_MIN      (V_MIN),
        .V_MAX      (V_MAX),
        .ACC_FRAMES (ACC_FRAMES)
    ) u_ramp (
        .clk   (clk),
        .reset (reset),
        .clear (state_chg_s),
        .step  (move_s),
        .clamp (move_s & clamp_s),
        .vel   (vel_s)
    );

    assign paddle_top = paddle_top_r;
    assign paddle_bot = paddle_top_r + Y_W'(PAD_H - 1);
    assign moving     = (state_r != IDLE);
    assign at_limit   = ((state_r == UP) && (paddle_top_r == TOP_LIM[Y_W-1:0])) ||
                        ((state_r == DN) && (paddle_top_r == BOT_LIM[Y_W-1:0]));

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Consumes the debounced up/down button levels and a once-per-frame tick from the VGA timing generator.
- Moves one pong paddle vertically with an accelerating velocity ramp.
- Clamps the paddle to the screen and publishes the paddle's top/bottom rows to the pixel-generation logic.
- Sits directly downstream of the button debouncers; one instance per paddle.

Parameters:
- Y_W, 10, width of row coordinates
- SCREEN_TOP, 0, topmost legal paddle row
- SCREEN_BOT, 479, bottommost legal paddle row
- PAD_H, 72, paddle height in rows
- Y_INIT, 204, paddle_top after reset
- V_MIN, 2, starting speed in rows/frame (>=1)
- V_MAX, 8, maximum speed in rows/frame (>=V_MIN)
- ACC_FRAMES, 4, moving frames per +1 speed step (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_up  in  1  debounced up level
- btn_dn  in  1  debounced down level
- frame_tick  in  1  one-cycle pulse per video frame
- paddle_top  out  Y_W  current top row
- paddle_bot  out  Y_W  paddle_top+PAD_H-1
- moving  out  1  state != IDLE
- at_limit  out  1  paddle pinned against the wall in its commanded direction

Behaviour:
- Single clock clk. Reset is synchronous, active-high, and overrides everything, including a concurrent frame_tick.
- Reset values: paddle_top=Y_INIT, paddle_bot=Y_INIT+PAD_H-1, moving=0, at_limit=0, state=IDLE, vel=V_MIN, acc_cnt=0.
- Direction decode each cycle: up_only=btn_up&~btn_dn; dn_only=btn_dn&~btn_up. Both pressed or neither pressed means no direction.
- States: IDLE, UP, DN. Transitions evaluate every clk, not only on frame_tick:
  - IDLE->UP on up_only; IDLE->DN on dn_only.
  - UP->DN on dn_only; DN->UP on up_only.
  - UP/DN->IDLE on no direction.
  - Any state change (entry, reversal, exit) loads vel=V_MIN and acc_cnt=0.
- Motion occurs only on frame_tick and only when state_reg==UP with up_only, or state_reg==DN with dn_only, in that same cycle.
  - A press coinciding with frame_tick moves nothing that frame.
  - A release coinciding with frame_tick moves nothing.
- UP move: paddle_top <= max(paddle_top - vel, SCREEN_TOP). Compute in Y_W+1 bits; the result never wraps.
- DN move: paddle_top <= min(paddle_top + vel, SCREEN_BOT-PAD_H+1). Compute in Y_W+1 bits.
- Ramp, applied on each moving frame_tick after the position update is computed with the old vel:
  - If acc_cnt==ACC_FRAMES-1: acc_cnt=0 and vel=min(vel+1, V_MAX).
  - Otherwise acc_cnt++.
- Clamping: a move that clamps loads vel=V_MIN and acc_cnt=0 instead of ramping.
- Outputs:
  - at_limit = (state_reg==UP && paddle_top==SCREEN_TOP) || (state_reg==DN && paddle_top==SCREEN_BOT-PAD_H+1), combinational from registers.
  - paddle_bot and moving are combinational from registers.
- Button inputs are already synchronised and debounced upstream; no additional filtering.

Decomposition:
- pong_pkg holds:
  - SCREEN_TOP/SCREEN_BOT, shared with the ball and pixel logic.
  - Paddle state encoding: IDLE=2'b00, UP=2'b01, DN=2'b10; 2'b11 returns to IDLE.
- One natural sub-module, paddle_vel_ramp: holds vel and acc_cnt, with inputs clear, step, clamp and output vel.

Test Plan:
- Reset: assert reset 2 cycles with frame_tick pulsing -> paddle_top=204, paddle_bot=275, moving=0, at_limit=0; no motion during reset.
- Ramp down: hold btn_dn, then issue 8 frame_ticks each at least 1 cycle after the press.
  - paddle_top sequence: 206,208,210,212,215,218,221,224.
  - moving=1 throughout.
- Bottom clamp: hold btn_dn for 60 frames.
  - paddle_top settles at 408 and paddle_bot at 479; at_limit=1.
  - Further ticks leave paddle_top at 408.
  - Releasing btn_dn drops at_limit and moving to 0.
- Top clamp without wrap: from 204, hold btn_up for 60 frames -> paddle_top reaches 0 and never shows >479; at_limit=1.
- Both buttons / reversal:
  - Hold btn_dn until vel=5, then press btn_up as well -> IDLE, no motion on following ticks.
  - Release btn_dn -> first up move is 2 rows.
  - A direct dn->up switch likewise restarts at 2.
- Coincident events:
  - Press btn_dn in the same cycle as frame_tick -> no move that frame; next tick moves 2.
  - Assert reset together with frame_tick mid-motion -> paddle_top=204 on the next cycle.
